// File: rtl/tx_split_pkg.sv
// Shared types, field offsets and packing helpers for the TCP tx segment splitter.
package tx_split_pkg;

  localparam int ST_SESS_LSB = 0;
  localparam int ST_TLEN_LSB = 16;
  localparam int ST_ERR_LSB  = 62;

  typedef enum logic [1:0] {
    ERR_OK     = 2'b00,
    ERR_RTO    = 2'b01,
    ERR_CLOSED = 2'b10,
    ERR_OTHER  = 2'b11
  } tx_err_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_META,
    S_DATA
  } split_state_e;

  typedef struct packed {
    logic [15:0] session;
    logic [31:0] length;
    logic [31:0] nseg;
  } req_entry_t;

  function automatic logic [31:0] pack_seg_meta(logic [15:0] len, logic [15:0] sess);
    return {len, sess};
  endfunction

  function automatic logic [63:0] pack_status(logic [1:0] err, logic [31:0] len,
                                              logic [15:0] sess);
    logic [63:0] s;
    s = '0;
    s[ST_SESS_LSB +: 16] = sess;
    s[ST_TLEN_LSB +: 32] = len;
    s[ST_ERR_LSB +: 2]   = err;
    return s;
  endfunction

  // Avoids the (a+b-1)/b overflow for lengths near 2^32.
  function automatic logic [31:0] ceil_div(logic [31:0] num, logic [31:0] den);
    logic [31:0] q;
    q = num / den;
    if ((num % den) != 32'd0) q = q + 32'd1;
    return q;
  endfunction

endpackage

// File: rtl/tx_data_split_seg_if.sv
// Valid/ready stream bundles: a plain word channel and a keep/last data channel.
interface axis_meta_if #(parameter int W = 32) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

interface axis_data_if #(parameter int DW = 512) ();
  logic            valid;
  logic            ready;
  logic            last;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] keep;

  modport master (output valid, data, keep, last, input ready);
  modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/tx_data_split_seg_status_merge.sv
// Outstanding-request FIFO that folds per-segment statuses into one status per request.
module tx_status_merge
  import tx_split_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic               push,
  input  req_entry_t         push_entry,
  output logic               full,
  axis_meta_if.slave         s_axis_tx_status,
  axis_meta_if.master        m_axis_tx_status,
  output logic [31:0]        orphan_cnt
);
  localparam int AW = $clog2(DEPTH);

  req_entry_t  mem [DEPTH];
  req_entry_t  head;
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [31:0] rcv_q, rcv_next;
  tx_err_e     err_q;
  logic [1:0]  err_next;
  logic        st_valid_q;
  logic [63:0] st_data_q;
  logic        empty, out_free, zero_head, st_fire, complete;

  assign head      = mem[rd_ptr_q[AW-1:0]];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign out_free  = !st_valid_q || m_axis_tx_status.ready;
  assign zero_head = !empty && (head.nseg == 32'd0);

  // A zero-segment head retires on its own; hold statuses off that cycle so none is miscounted.
  assign s_axis_tx_status.ready = en && out_free && !zero_head;
  assign st_fire  = s_axis_tx_status.valid && s_axis_tx_status.ready;
  assign rcv_next = rcv_q + 32'd1;
  assign err_next = err_q | s_axis_tx_status.data[ST_ERR_LSB +: 2];
  assign complete = out_free && (zero_head || (st_fire && !empty && rcv_next == head.nseg));

  assign m_axis_tx_status.valid = st_valid_q;
  assign m_axis_tx_status.data  = st_data_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rcv_q      <= '0;
      err_q      <= ERR_OK;
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
      orphan_cnt <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (complete) begin
        rd_ptr_q   <= rd_ptr_q + (AW+1)'(1);
        rcv_q      <= '0;
        err_q      <= ERR_OK;
        st_valid_q <= 1'b1;
        st_data_q  <= pack_status(st_fire ? err_next : err_q, head.length, head.session);
      end else begin
        if (st_fire && !empty) begin
          rcv_q <= rcv_next;
          err_q <= tx_err_e'(err_next);
        end
        if (m_axis_tx_status.ready) st_valid_q <= 1'b0;
      end
      if (st_fire && empty && orphan_cnt != '1) orphan_cnt <= orphan_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/tx_data_split_seg.sv
// Splits large tx requests into fixed-size TCP segments and merges their statuses.
// state  | meaning
// IDLE   | waiting for a request; accepts when the status FIFO has room
// META   | presenting {seglen, session} for the next segment
// DATA   | passing payload beats through until the segment's final beat
module tx_data_split_seg
  import tx_split_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int DEFAULT_SEG     = 4096,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] seg_size,
  axis_meta_if.slave  s_axis_tx_metadata,
  axis_data_if.slave  s_axis_tx_data,
  axis_meta_if.master m_axis_tx_status,
  axis_meta_if.master m_axis_tx_metadata,
  axis_data_if.master m_axis_tx_data,
  axis_meta_if.slave  s_axis_tx_status,
  output logic [31:0] orphan_cnt
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);

  split_state_e     state_q, state_d;
  logic             live_q;
  logic [15:0]      session_q, eseg_q, beats_q;
  logic [31:0]      remaining_q;
  logic [15:0]      seg_masked, eseg_c, seglen, beats_init;
  logic [LB-1:0]    resid;
  logic [BYTES-1:0] tail_keep;
  logic [31:0]      req_len;
  logic [15:0]      req_sess;
  logic             fifo_full, req_fire, meta_fire, beat_fire, final_beat;

  assign req_len    = s_axis_tx_metadata.data[47:16];
  assign req_sess   = s_axis_tx_metadata.data[15:0];
  assign seg_masked = seg_size & ~16'(BYTES - 1);
  assign eseg_c     = (seg_masked == 16'd0) ? 16'(DEFAULT_SEG) : seg_masked;
  assign seglen     = (remaining_q < {16'd0, eseg_q}) ? remaining_q[15:0] : eseg_q;
  assign resid      = seglen[LB-1:0];
  assign beats_init = (seglen >> LB) + {15'd0, |resid};
  assign tail_keep  = ~({BYTES{1'b1}} << resid);
  assign final_beat = (beats_q == 16'd1);

  assign req_fire  = (state_q == S_IDLE) && live_q && !fifo_full && s_axis_tx_metadata.valid;
  assign meta_fire = (state_q == S_META) && m_axis_tx_metadata.ready;
  assign beat_fire = (state_q == S_DATA) && s_axis_tx_data.valid && m_axis_tx_data.ready;

  always_comb begin
    state_d                  = state_q;
    s_axis_tx_metadata.ready = 1'b0;
    m_axis_tx_metadata.valid = 1'b0;
    m_axis_tx_metadata.data  = pack_seg_meta(seglen, session_q);
    s_axis_tx_data.ready     = 1'b0;
    m_axis_tx_data.valid     = 1'b0;
    m_axis_tx_data.data      = s_axis_tx_data.data;
    m_axis_tx_data.keep      = '1;
    m_axis_tx_data.last      = 1'b0;
    case (state_q)
      S_IDLE: begin
        s_axis_tx_metadata.ready = live_q && !fifo_full;
        if (req_fire && req_len != 32'd0) state_d = S_META;
      end
      S_META: begin
        m_axis_tx_metadata.valid = 1'b1;
        if (meta_fire) state_d = S_DATA;
      end
      S_DATA: begin
        s_axis_tx_data.ready = m_axis_tx_data.ready;
        m_axis_tx_data.valid = s_axis_tx_data.valid;
        m_axis_tx_data.last  = final_beat;
        if (final_beat && resid != '0) m_axis_tx_data.keep = tail_keep;
        if (beat_fire && final_beat)
          state_d = (remaining_q == {16'd0, seglen}) ? S_IDLE : S_META;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      session_q   <= '0;
      eseg_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (req_fire) begin
        session_q   <= req_sess;
        remaining_q <= req_len;
        eseg_q      <= eseg_c;
      end
      if (meta_fire) beats_q <= beats_init;
      if (beat_fire) begin
        beats_q <= beats_q - 16'd1;
        if (final_beat) remaining_q <= remaining_q - {16'd0, seglen};
      end
    end
  end

  tx_status_merge #(.DEPTH(MAX_OUTSTANDING)) u_merge (
    .clk              (clk),
    .rstn             (rstn),
    .en               (live_q),
    .push             (req_fire),
    .push_entry       ('{session: req_sess, length: req_len,
                         nseg: ceil_div(req_len, {16'd0, eseg_c})}),
    .full             (fifo_full),
    .s_axis_tx_status (s_axis_tx_status),
    .m_axis_tx_status (m_axis_tx_status),
    .orphan_cnt       (orphan_cnt)
  );

endmodule

// File: tb/tb_tx_data_split_seg.sv
// Scoreboard bench for tx_data_split_seg: table vectors plus hand-built back-pressure,
// full-FIFO, orphan and mid-request reset sequences.
`timescale 1ns/1ps
module tb_tx_data_split_seg;
  localparam int DW    = 512;
  localparam int BYTES = DW / 8;
  localparam int MAXO  = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] seg_size = 16'd0;
  logic [31:0] orphan_cnt;

  axis_meta_if #(.W(48)) s_meta ();
  axis_data_if #(.DW(DW)) s_data ();
  axis_meta_if #(.W(64)) m_status ();
  axis_meta_if #(.W(32)) m_meta ();
  axis_data_if #(.DW(DW)) m_data ();
  axis_meta_if #(.W(64)) s_status ();

  tx_data_split_seg #(.DATA_WIDTH(DW), .DEFAULT_SEG(4096), .MAX_OUTSTANDING(MAXO)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .seg_size           (seg_size),
    .s_axis_tx_metadata (s_meta),
    .s_axis_tx_data     (s_data),
    .m_axis_tx_status   (m_status),
    .m_axis_tx_metadata (m_meta),
    .m_axis_tx_data     (m_data),
    .s_axis_tx_status   (s_status),
    .orphan_cnt         (orphan_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] len; logic [15:0] sess; logic [1:0] err; } req_t;
  typedef struct { logic [DW-1:0] data; logic [BYTES-1:0] keep; logic last; } beat_t;
  typedef struct {
    logic [15:0] seg; logic [31:0] len; logic [15:0] sess; logic [1:0] err;
    int exp_segs; logic [BYTES-1:0] exp_keep; logic [63:0] exp_status;
  } vec_t;

  req_t          req_q[$];
  logic [DW-1:0] src_q[$];
  logic [31:0]   exp_meta_q[$];
  logic [1:0]    seg_err_q[$];
  beat_t         exp_data_q[$];
  logic [63:0]   exp_st_q[$];
  logic [63:0]   stq[$];

  int checks = 0;
  int errors = 0;
  int st_budget = 1 << 30;
  bit rnd = 1'b0;
  int meta_seen = 0;
  int st_seen = 0;
  logic [BYTES-1:0] last_keep_seen = '0;
  logic [63:0]      last_st_seen = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Expected segments, beats and aggregated status for one accepted request.
  task automatic model_req(input req_t r);
    logic [15:0] es, sl;
    logic [31:0] rem;
    int nb;
    beat_t b;
    es = seg_size & 16'hFFC0;
    if (es == 16'd0) es = 16'd4096;
    rem = r.len;
    while (rem != 32'd0) begin
      sl = (rem < {16'd0, es}) ? rem[15:0] : es;
      exp_meta_q.push_back({sl, r.sess});
      seg_err_q.push_back((rem == {16'd0, sl}) ? r.err : 2'b00);
      nb = (int'(sl) + BYTES - 1) / BYTES;
      for (int i = 0; i < nb; i++) begin
        for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
        b.last = (i == nb - 1);
        b.keep = '1;
        if (b.last && (int'(sl) % BYTES) != 0) begin
          b.keep = '0;
          for (int k = 0; k < int'(sl) % BYTES; k++) b.keep[k] = 1'b1;
        end
        src_q.push_back(b.data);
        exp_data_q.push_back(b);
      end
      rem = rem - {16'd0, sl};
    end
    exp_st_q.push_back({(r.len != 0) ? r.err : 2'b00, 14'd0, r.len, r.sess});
  endtask

  initial begin : engine
    req_t r;
    logic [31:0] em;
    logic [1:0] se;
    beat_t eb;
    logic [63:0] es;
    logic [DW-1:0] dsc;
    logic [63:0] ssc;
    logic f_req, f_src, f_sin, f_meta, f_dat, f_sto;
    forever begin
      @(negedge clk);
      f_req  = s_meta.valid && s_meta.ready;
      f_src  = s_data.valid && s_data.ready;
      f_sin  = s_status.valid && s_status.ready;
      f_meta = m_meta.valid && m_meta.ready;
      f_dat  = m_data.valid && m_data.ready;
      f_sto  = m_status.valid && m_status.ready;
      if (f_req) begin
        r = req_q.pop_front();
        model_req(r);
      end
      if (f_src) dsc = src_q.pop_front();
      if (f_sin) begin
        ssc = stq.pop_front();
        st_budget--;
      end
      if (f_meta) begin
        meta_seen++;
        if (exp_meta_q.size() == 0) chk("meta_unexpected", {32'd0, m_meta.data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          em = exp_meta_q.pop_front();
          se = seg_err_q.pop_front();
          chk("seg_meta", {32'd0, m_meta.data}, {32'd0, em});
          stq.push_back({se, 30'd0, em});
        end
      end
      if (f_dat) begin
        checks++;
        if (m_data.last) last_keep_seen = m_data.keep;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL data_unexpected got keep=%h last=%b expected no beat", m_data.keep, m_data.last);
        end else begin
          eb = exp_data_q.pop_front();
          if (m_data.data !== eb.data || m_data.keep !== eb.keep || m_data.last !== eb.last) begin
            errors++;
            $display("FAIL data_beat got data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                     m_data.data, m_data.keep, m_data.last, eb.data, eb.keep, eb.last);
          end
        end
      end
      if (f_sto) begin
        st_seen++;
        last_st_seen = m_status.data;
        if (exp_st_q.size() == 0) chk("status_unexpected", m_status.data, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          es = exp_st_q.pop_front();
          chk("agg_status", m_status.data, es);
        end
      end
      @(posedge clk);
      #1;
      s_meta.valid = (req_q.size() > 0);
      s_meta.data  = (req_q.size() > 0) ? {req_q[0].len, req_q[0].sess} : 48'd0;
      if (!(s_data.valid && !f_src)) begin
        s_data.valid = (src_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
        s_data.data  = (src_q.size() > 0) ? src_q[0] : '0;
      end
      if (!(s_status.valid && !f_sin)) begin
        s_status.valid = (stq.size() > 0) && (st_budget > 0) && (!rnd || $urandom_range(0, 2) != 0);
        s_status.data  = (stq.size() > 0) ? stq[0] : 64'd0;
      end
      m_meta.ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_data.ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_status.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check_outputs_idle(input string tag);
    chk({tag, "_meta_in_ready"}, {63'd0, s_meta.ready}, 64'd0);
    chk({tag, "_data_in_ready"}, {63'd0, s_data.ready}, 64'd0);
    chk({tag, "_status_in_ready"}, {63'd0, s_status.ready}, 64'd0);
    chk({tag, "_meta_valid"}, {63'd0, m_meta.valid}, 64'd0);
    chk({tag, "_data_valid"}, {63'd0, m_data.valid}, 64'd0);
    chk({tag, "_status_valid"}, {63'd0, m_status.valid}, 64'd0);
    chk({tag, "_orphan_cnt"}, {32'd0, orphan_cnt}, 64'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    req_q.delete(); src_q.delete(); exp_meta_q.delete(); seg_err_q.delete();
    exp_data_q.delete(); exp_st_q.delete(); stq.delete();
    s_meta.valid = 1'b0;
    s_data.valid = 1'b0;
    s_status.valid = 1'b0;
    #1;
    check_outputs_idle(tag);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((req_q.size() + src_q.size() + exp_meta_q.size() + exp_data_q.size() +
            exp_st_q.size() + stq.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drained"}, {63'd0, (n >= budget)}, 64'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    vec_t vecs[3];
    int n;
    s_meta.valid = 1'b0;   s_meta.data = '0;
    s_data.valid = 1'b0;   s_data.data = '0;   s_data.keep = '1;   s_data.last = 1'b1;
    s_status.valid = 1'b0; s_status.data = '0;
    m_meta.ready = 1'b1;   m_data.ready = 1'b1; m_status.ready = 1'b1;

    vecs[0] = '{seg: 16'h1000, len: 32'h0004_0000, sess: 16'h0000, err: 2'b00, exp_segs: 64,
                exp_keep: '1, exp_status: 64'h0000_0004_0000_0000};
    vecs[1] = '{seg: 16'h0000, len: 32'd100, sess: 16'h0007, err: 2'b00, exp_segs: 1,
                exp_keep: 64'h0000_000F_FFFF_FFFF, exp_status: 64'h0000_0000_0064_0007};
    vecs[2] = '{seg: 16'h1010, len: 32'h0000_2000, sess: 16'h0003, err: 2'b10, exp_segs: 2,
                exp_keep: '1, exp_status: 64'h8000_0000_2000_0003};

    apply_reset("reset");
    repeat (2) @(posedge clk);
    #1;
    chk("live_meta_ready", {63'd0, s_meta.ready}, 64'd1);
    chk("live_status_ready", {63'd0, s_status.ready}, 64'd1);

    // Statuses with nothing outstanding.
    stq.push_back(64'h0000_0000_0040_0009);
    stq.push_back(64'hC000_0000_0040_0009);
    wait_idle(200, "orphan");
    chk("orphan_cnt", {32'd0, orphan_cnt}, 64'd2);

    for (int i = 0; i < 3; i++) begin
      seg_size = vecs[i].seg;
      meta_seen = 0;
      req_q.push_back('{len: vecs[i].len, sess: vecs[i].sess, err: vecs[i].err});
      wait_idle(20000, "vec");
      chk("vec_segments", 64'(meta_seen), 64'(vecs[i].exp_segs));
      chk("vec_last_keep", {{(64-BYTES){1'b0}}, last_keep_seen}, {{(64-BYTES){1'b0}}, vecs[i].exp_keep});
      chk("vec_status", last_st_seen, vecs[i].exp_status);
    end

    // Back-to-back requests under random back-pressure, including a zero-length one.
    rnd = 1'b1;
    seg_size = 16'h1000;
    st_seen = 0;
    req_q.push_back('{len: 32'd0, sess: 16'h0010, err: 2'b00});
    req_q.push_back('{len: 32'd65, sess: 16'h0011, err: 2'b01});
    req_q.push_back('{len: 32'h3000, sess: 16'h0012, err: 2'b00});
    wait_idle(20000, "random");
    rnd = 1'b0;
    chk("random_status_count", 64'(st_seen), 64'd3);
    chk("random_last_status", last_st_seen, 64'h0000_0000_3000_0012);

    // Fill the outstanding FIFO with statuses withheld.
    st_budget = 0;
    seg_size = 16'd0;
    for (int i = 0; i < MAXO; i++) req_q.push_back('{len: 32'd64, sess: 16'(16'h0200 + i), err: 2'b00});
    n = 0;
    while ((req_q.size() + exp_data_q.size()) != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("fill_done", {63'd0, (n >= 2000)}, 64'd0);
    req_q.push_back('{len: 32'd64, sess: 16'h0300, err: 2'b00});
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_meta_valid", {63'd0, s_meta.valid}, 64'd1);
    chk("full_meta_ready", {63'd0, s_meta.ready}, 64'd0);
    chk("full_req_pending", 64'(req_q.size()), 64'd1);
    st_budget = 1;
    n = 0;
    while (req_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("slot_freed_accept", {63'd0, (n >= 200)}, 64'd0);
    st_budget = 1 << 30;
    wait_idle(5000, "full_drain");
    chk("full_last_status", last_st_seen, 64'h0000_0000_0040_0300);

    // Reset in the middle of a segment's payload.
    req_q.push_back('{len: 32'h1000, sess: 16'h0033, err: 2'b00});
    n = 0;
    while (exp_data_q.size() > 40 || exp_meta_q.size() != 0 || req_q.size() != 0) begin
      if (n >= 500) break;
      @(posedge clk);
      n++;
    end
    chk("mid_data_reached", {63'd0, (n >= 500)}, 64'd0);
    apply_reset("mid_reset");
    repeat (2) @(posedge clk);
    st_seen = 0;
    req_q.push_back('{len: 32'd200, sess: 16'h0034, err: 2'b00});
    wait_idle(2000, "post_reset");
    chk("post_reset_status_count", 64'(st_seen), 64'd1);
    chk("post_reset_status", last_st_seen, 64'h0000_0000_00C8_0034);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
